alu_sched: RTL and testbench

Round-robin scheduler that shares the 4-bit ALU between several requesters. It arbitrates requests, latches the winner's operands and opcode, and drives the ALU for one execute cycle. It then registers the result and flags and returns them to the winner with a one-cycle done pulse. It sits between the front-end sources (switch inputs, sequencers) and the shared `alu`. Its registered result also feeds the `number` display path.

---
 rtl/alu_sched_defs.sv | 14 +
 rtl/alu_sched_rr_arbiter.sv | 39 +++
 rtl/alu_sched.sv | 126 ++++++++++++
 tb/tb_alu_sched.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_defs.sv
// Shared definitions for the ALU round-robin scheduler: FSM encodings and widths.
package alu_sched_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_EXEC  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int ALUC_W = 4;
    localparam int DEF_W  = 4;

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// Combinational round-robin picker: first eligible request at or after ptr, wrapping.
module rr_arbiter
    import alu_sched_defs::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] mask,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic            any,
    output logic [IW-1:0]   idx
);

    logic [NREQ-1:0] eligible;

    assign eligible = req & ~mask;

    always_comb begin
        int j;
        gnt = '0;
        any = 1'b0;
        idx = '0;
        j   = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!any && eligible[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one external ALU between NREQ requesters.
// Define ALU_SCHED_STATS_EN to build the saturating completed-operation counter.
module alu_sched
    import alu_sched_defs::*;
#(
    parameter int  NREQ = 2,
    parameter int  W    = DEF_W,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*W-1:0]      a_in,
    input  logic [NREQ*W-1:0]      b_in,
    input  logic [NREQ*ALUC_W-1:0] op_in,
    output logic [NREQ-1:0]        grant,
    output logic [W-1:0]           alu_a,
    output logic [W-1:0]           alu_b,
    output logic [ALUC_W-1:0]      alu_op,
    output logic                   alu_cin,
    input  logic [W-1:0]           alu_res,
    input  logic                   alu_cf,
    input  logic                   alu_zf,
    output logic                   done,
    output logic [IW-1:0]          done_id,
    output logic [W-1:0]           res_out,
    output logic                   cf_out,
    output logic                   zf_out,
    output logic                   busy,
    output logic [7:0]             op_cnt
);

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   win_idx;
    logic [NREQ-1:0] arb_mask;
    logic [NREQ-1:0] arb_gnt;
    logic            arb_any;
    logic [IW-1:0]   arb_idx;
    logic [IW-1:0]   next_ptr;
    logic            take;

    // In DONE the served requester still holds req, so it is masked out of re-arbitration.
    assign arb_mask = (state == ST_DONE) ? grant : '0;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req  (req),
        .mask (arb_mask),
        .ptr  (ptr),
        .gnt  (arb_gnt),
        .any  (arb_any),
        .idx  (arb_idx)
    );

    assign next_ptr = (int'(arb_idx) == NREQ - 1) ? '0 : arb_idx + 1'b1;
    assign take     = arb_any && ((state == ST_IDLE) || (state == ST_DONE));
    assign busy     = (state != ST_IDLE);
    assign alu_cin  = 1'b0;
    assign done_id  = win_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            win_idx <= '0;
            grant   <= '0;
            done    <= 1'b0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            res_out <= '0;
            cf_out  <= 1'b0;
            zf_out  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (take) begin
                alu_a   <= a_in[int'(arb_idx)*W +: W];
                alu_b   <= b_in[int'(arb_idx)*W +: W];
                alu_op  <= op_in[int'(arb_idx)*ALUC_W +: ALUC_W];
                grant   <= arb_gnt;
                win_idx <= arb_idx;
                ptr     <= next_ptr;
            end
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    res_out <= alu_res;
                    cf_out  <= alu_cf;
                    zf_out  <= alu_zf;
                    done    <= 1'b1;
                    state   <= ST_DONE;
                end
                ST_DONE: begin
                    if (!arb_any) begin
                        grant <= '0;
                    end
                    state <= arb_any ? ST_GRANT : ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SCHED_STATS_EN
    // Counts on the EXEC->DONE edge so the new value appears together with done.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_cnt <= '0;
        end else if (state == ST_EXEC && op_cnt != 8'hFF) begin
            op_cnt <= op_cnt + 8'd1;
        end
    end
`else
    assign op_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched with a small behavioural ALU beside it.
module tb_alu_sched;

    localparam int NREQ = 2;
    localparam int W    = 4;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*W-1:0] a_in = '0;
    logic [NREQ*W-1:0] b_in = '0;
    logic [NREQ*4-1:0] op_in = '0;
    logic [NREQ-1:0]   grant;
    logic [W-1:0]      alu_a, alu_b;
    logic [3:0]        alu_op;
    logic              alu_cin;
    logic [W-1:0]      alu_res;
    logic              alu_cf, alu_zf;
    logic              done;
    logic [0:0]        done_id;
    logic [W-1:0]      res_out;
    logic              cf_out, zf_out;
    logic              busy;
    logic [7:0]        op_cnt;

    int total = 0;
    int bad   = 0;
    int seen  = 0;

    always #5 clk = ~clk;

    alu_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .a_in    (a_in),
        .b_in    (b_in),
        .op_in   (op_in),
        .grant   (grant),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_op  (alu_op),
        .alu_cin (alu_cin),
        .alu_res (alu_res),
        .alu_cf  (alu_cf),
        .alu_zf  (alu_zf),
        .done    (done),
        .done_id (done_id),
        .res_out (res_out),
        .cf_out  (cf_out),
        .zf_out  (zf_out),
        .busy    (busy),
        .op_cnt  (op_cnt)
    );

    // Parent-level ALU model
    logic [4:0] sum;
    always_comb begin
        sum = '0;
        case (alu_op)
            OP_ADD:  sum = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB:  sum = {1'b0, alu_a} - {1'b0, alu_b};
            OP_AND:  sum = {1'b0, alu_a & alu_b};
            OP_OR:   sum = {1'b0, alu_a | alu_b};
            OP_XOR:  sum = {1'b0, alu_a ^ alu_b};
            default: sum = {1'b0, alu_a};
        endcase
        alu_res = sum[3:0];
        alu_cf  = sum[4];
        alu_zf  = (sum[3:0] == 4'd0);
    end

    typedef struct {
        int         id;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
        logic [3:0] res;
        logic       cf;
        logic       zf;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
        if (rst) seen = 0;
        else if (done) seen++;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int id, input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        a_in[id*W +: W] = a;
        b_in[id*W +: W] = b;
        op_in[id*4 +: 4] = op;
        req[id] = 1'b1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        req = '0;
        step();
        rst = 1'b0;
    endtask

    function automatic int expCnt(input int s);
`ifdef ALU_SCHED_STATS_EN
        return (s > 255) ? 255 : s;
`else
        return 0 * s;
`endif
    endfunction

    initial begin
        int cyc;
        int nd;
        int last;
        int chk;
        bit after_done;
        bit dropnext;
        bit reassert;

        vecs[0] = '{0, 4'h7, 4'h9, OP_ADD, 4'h0, 1'b1, 1'b1};
        vecs[1] = '{1, 4'h3, 4'h4, OP_ADD, 4'h7, 1'b0, 1'b0};
        vecs[2] = '{0, 4'h5, 4'h5, OP_SUB, 4'h0, 1'b0, 1'b1};
        vecs[3] = '{1, 4'h2, 4'h5, OP_SUB, 4'hD, 1'b1, 1'b0};
        vecs[4] = '{0, 4'hC, 4'hA, OP_AND, 4'h8, 1'b0, 1'b0};
        vecs[5] = '{1, 4'hF, 4'hF, OP_XOR, 4'h0, 1'b0, 1'b1};
        vecs[6] = '{0, 4'hC, 4'h3, OP_OR,  4'hF, 1'b0, 1'b0};

        $display("[TB] reset state");
        step();
        step();
        checkOutput("rst_grant",   32'(grant),   0);
        checkOutput("rst_done",    32'(done),    0);
        checkOutput("rst_busy",    32'(busy),    0);
        checkOutput("rst_res",     32'(res_out), 0);
        checkOutput("rst_cf",      32'(cf_out),  0);
        checkOutput("rst_zf",      32'(zf_out),  0);
        checkOutput("rst_done_id", 32'(done_id), 0);
        checkOutput("rst_op_cnt",  32'(op_cnt),  0);
        checkOutput("rst_alu_a",   32'(alu_a),   0);
        checkOutput("rst_alu_op",  32'(alu_op),  0);
        checkOutput("rst_cin",     32'(alu_cin), 0);
        rst = 1'b0;

        $display("[TB] single-request vectors");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op);
            step();
            checkOutput($sformatf("v%0d_grant", i), 32'(grant), 32'(1) << vecs[i].id);
            checkOutput($sformatf("v%0d_busy", i), 32'(busy), 1);
            step();
            checkOutput($sformatf("v%0d_early_done", i), 32'(done), 0);
            step();
            checkOutput($sformatf("v%0d_done", i), 32'(done), 1);
            checkOutput($sformatf("v%0d_done_id", i), 32'(done_id), 32'(vecs[i].id));
            checkOutput($sformatf("v%0d_res", i), 32'(res_out), 32'(vecs[i].res));
            checkOutput($sformatf("v%0d_cf", i), 32'(cf_out), 32'(vecs[i].cf));
            checkOutput($sformatf("v%0d_zf", i), 32'(zf_out), 32'(vecs[i].zf));
            step();
            req = '0;
            checkOutput($sformatf("v%0d_idle", i), 32'(busy), 0);
            checkOutput($sformatf("v%0d_grant_clr", i), 32'(grant), 0);
            checkOutput($sformatf("v%0d_hold_res", i), 32'(res_out), 32'(vecs[i].res));
        end
        checkOutput("vec_op_cnt", 32'(op_cnt), 32'(expCnt(seen)));

        $display("[TB] reset during EXEC");
        applyStimulus(0, 4'h1, 4'h1, OP_ADD);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = '0;
        checkOutput("mid_busy",  32'(busy),    0);
        checkOutput("mid_grant", 32'(grant),   0);
        checkOutput("mid_res",   32'(res_out), 0);
        checkOutput("mid_done",  32'(done),    0);
        checkOutput("mid_alu_a", 32'(alu_a),   0);
        checkOutput("mid_cnt",   32'(op_cnt),  0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("mid_no_done", 32'(done), 0);
        end

        $display("[TB] simultaneous requests");
        doReset();
        applyStimulus(0, 4'h1, 4'h2, OP_ADD);
        applyStimulus(1, 4'h4, 4'h4, OP_ADD);
        step();
        checkOutput("sim_grant0", 32'(grant), 1);
        step();
        checkOutput("sim_c2_done", 32'(done), 0);
        step();
        checkOutput("sim_done0",  32'(done),    1);
        checkOutput("sim_id0",    32'(done_id), 0);
        checkOutput("sim_res0",   32'(res_out), 3);
        step();
        req[0] = 1'b0;
        checkOutput("sim_grant1", 32'(grant), 2);
        checkOutput("sim_c4_done", 32'(done), 0);
        step();
        step();
        checkOutput("sim_done1",  32'(done),    1);
        checkOutput("sim_id1",    32'(done_id), 1);
        checkOutput("sim_res1",   32'(res_out), 8);
        step();
        req[1] = 1'b0;
        checkOutput("sim_idle", 32'(busy), 0);
        checkOutput("sim_cnt",  32'(op_cnt), 32'(expCnt(seen)));
        req = 2'b11;
        step();
        checkOutput("sim_ptr_wrap", 32'(grant), 1);

        $display("[TB] alternation");
        doReset();
        applyStimulus(0, 4'h2, 4'h3, OP_ADD);
        applyStimulus(1, 4'h6, 4'h1, OP_SUB);
        cyc = 0;
        nd = 0;
        last = -1;
        dropnext = 0;
        reassert = 0;
        while (nd < 4 && cyc < 40) begin
            step();
            cyc++;
            if (reassert) begin
                req[0] = 1'b1;
                reassert = 0;
            end
            if (dropnext) begin
                req[0] = 1'b0;
                dropnext = 0;
                reassert = 1;
            end
            if (done) begin
                checkOutput($sformatf("alt_id%0d", nd), 32'(done_id), 32'(nd % 2));
                checkOutput($sformatf("alt_res%0d", nd), 32'(res_out), (nd % 2 == 0) ? 5 : 5);
                if (last < 0) checkOutput("alt_first_cycle", cyc, 3);
                else checkOutput($sformatf("alt_gap%0d", nd), cyc - last, 3);
                if (done_id == 1'b0) dropnext = 1;
                last = cyc;
                nd++;
            end
        end
        checkOutput("alt_count", nd, 4);
        checkOutput("alt_cnt", 32'(op_cnt), 32'(expCnt(seen)));

        $display("[TB] single requester repeating");
        doReset();
        applyStimulus(0, 4'h9, 4'h9, OP_ADD);
        cyc = 0;
        last = -1;
        chk = 0;
        after_done = 0;
        while (seen < 300 && cyc < 2000) begin
            step();
            cyc++;
            if (after_done && chk < 4) checkOutput("rep_idle_after_done", 32'(busy), 0);
            after_done = 0;
            if (done) begin
                if (last < 0) begin
                    checkOutput("rep_first_cycle", cyc, 3);
                    checkOutput("rep_res", 32'(res_out), 2);
                    checkOutput("rep_cf", 32'(cf_out), 1);
                end else if (chk < 4) begin
                    checkOutput($sformatf("rep_gap%0d", chk), cyc - last, 4);
                    chk++;
                end
                last = cyc;
                after_done = 1;
            end
            if (seen == 10 && done) checkOutput("rep_cnt10", 32'(op_cnt), 32'(expCnt(10)));
        end
        checkOutput("rep_reached_300", (seen >= 300) ? 1 : 0, 1);
        req = '0;
        for (int i = 0; i < 3; i++) step();
        checkOutput("rep_cnt_final", 32'(op_cnt), 32'(expCnt(300)));
        checkOutput("rep_final_busy", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
